// File: rtl/div_sqrt_mant_iter_ctrl.sv
// Sequential radix-2 non-restoring mantissa divider / square-root engine.
// One result bit per cycle, then one cycle of remainder sign correction and sticky evaluation.
module div_sqrt_mant_iter_ctrl #(
  parameter int WIDTH = 25,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk_CI,
  input  logic             Rst_RI,
  input  logic             Div_start_SI,
  input  logic             Sqrt_start_SI,
  input  logic             Kill_SI,
  input  logic [WIDTH-1:0] Operand_a_DI,
  input  logic [WIDTH-1:0] Operand_b_DI,
  input  logic             Exp_odd_SI,
  output logic             Ready_SO,
  output logic             Done_SO,
  output logic [WIDTH-1:0] Result_DO,
  output logic             Sticky_SO,
  output logic [1:0]       Fsm_state_SO
);

  localparam int RW = WIDTH + 2;

  // Handshake: a start (Div_start_SI or Sqrt_start_SI) is accepted on any rising edge where
  // Ready_SO=1 and Kill_SI=0; Done_SO is a one-cycle strobe qualifying Result_DO/Sticky_SO.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [RW-1:0]        rem_q;
  logic [WIDTH-1:0]     quo_q;
  logic [WIDTH-1:0]     divisor_q;
  logic [2*WIDTH-1:0]   rad_q;
  logic                 is_div_q;

  logic                 start_req;
  logic                 accept;
  logic                 last_cycle;
  logic                 div_enable;
  logic                 sqrt_enable;
  logic [RW-1:0]        cell_a;
  logic [RW-1:0]        cell_b;
  logic [1:0]           cell_d;
  logic                 cell_sub;
  logic [RW-1:0]        cell_sum;
  logic                 cell_carry;
  logic [RW-1:0]        rem_fix;
  logic [RW-1:0]        rem_final;
  logic                 sticky_d;

  assign start_req  = Div_start_SI | Sqrt_start_SI;
  assign accept     = (state_q != ITER) & start_req & ~Kill_SI;
  assign last_cycle = (cnt_q == CNT_W'(WIDTH));

  assign Ready_SO     = (state_q != ITER);
  assign Done_SO      = (state_q == DONE);
  assign Fsm_state_SO = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = ITER;
      end
      ITER: begin
        if (Kill_SI)         state_d = IDLE;
        else if (last_cycle) state_d = DONE;
      end
      DONE: begin
        if (accept) state_d = ITER;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Iteration cell. The sign of the previous partial remainder picks add or subtract;
  // the carry (non-negative result) is the next result bit.
  assign div_enable  = is_div_q;
  assign sqrt_enable = ~is_div_q;
  assign cell_d      = rad_q[2*WIDTH-1 -: 2];
  assign cell_sub    = ~rem_q[RW-1];

  always_comb begin
    cell_a = '0;
    cell_b = '0;
    if (div_enable) begin
      // The first divide step compares A against B directly, without doubling.
      cell_a = (cnt_q == '0) ? rem_q : {rem_q[RW-2:0], 1'b0};
      cell_b = {2'b00, divisor_q};
    end else if (sqrt_enable) begin
      cell_a = {rem_q[RW-3:0], cell_d};
      cell_b = {quo_q, rem_q[RW-1], 1'b1};
    end
  end

  assign cell_sum   = cell_sub ? (cell_a - cell_b) : (cell_a + cell_b);
  assign cell_carry = ~cell_sum[RW-1];

  // A negative final remainder is restored by adding back B (divide) or 2*root+1 (sqrt).
  assign rem_fix   = is_div_q ? {2'b00, divisor_q} : {1'b0, quo_q, 1'b1};
  assign rem_final = rem_q[RW-1] ? (rem_q + rem_fix) : rem_q;
  assign sticky_d  = |rem_final;

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      rad_q     <= '0;
      is_div_q  <= 1'b0;
      Result_DO <= '0;
      Sticky_SO <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q     <= '0;
        is_div_q  <= Div_start_SI;
        divisor_q <= Operand_b_DI;
        quo_q     <= '0;
        rem_q     <= Div_start_SI ? {2'b00, Operand_a_DI} : '0;
        rad_q     <= Exp_odd_SI ? {Operand_a_DI, {WIDTH{1'b0}}}
                                : {1'b0, Operand_a_DI, {(WIDTH-1){1'b0}}};
      end else if ((state_q == ITER) && !Kill_SI) begin
        if (!last_cycle) begin
          rem_q <= cell_sum;
          quo_q <= {quo_q[WIDTH-2:0], cell_carry};
          rad_q <= {rad_q[2*WIDTH-3:0], 2'b00};
          cnt_q <= cnt_q + CNT_W'(1);
        end else begin
          Result_DO <= quo_q;
          Sticky_SO <= sticky_d;
        end
      end
    end
  end

endmodule
